// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: state encoding and default widths shared by rx_burst_ctrl and its output register
package rx_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HDR   = 2'd3
    } state_t;
    localparam int LEN_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int HDR_W     = 64;
endpackage

// File: rtl/rx_out_reg.sv
// rx_out_reg: one-entry valid/ready output register; a load during accept replaces the word in place
module rx_out_reg
    import rx_ctrl_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [HDR_W-1:0] ld_data,
    input  logic             ld_sop,
    input  logic             ld_eop,
    input  logic             ready,
    output logic [HDR_W-1:0] q_data,
    output logic             q_valid,
    output logic             q_sop,
    output logic             q_eop
);
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            q_data  <= '0;
            q_valid <= 1'b0;
            q_sop   <= 1'b0;
            q_eop   <= 1'b0;
        end else if (load) begin
            q_data  <= ld_data;
            q_valid <= 1'b1;
            q_sop   <= ld_sop;
            q_eop   <= ld_eop;
        end else if (ready & q_valid) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/rx_burst_ctrl.sv
// rx_burst_ctrl: frames receiver sample words into sop/eop bursts of cfg_len words, dropping samples while blocked.
// Define RX_TIMESTAMP_EN to prefix each burst with a 64-bit sample-count header word.
module rx_burst_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_continuous,
    input  logic [63:0]      smp_data,
    input  logic             smp_valid,
    output logic [63:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sop,
    output logic             m_eop,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] burst_cnt
);
    state_t           state, state_nx;
    logic [LEN_W-1:0] len, wcnt;
    logic             cont, stop_pending;
    logic             free, start_ok, load_pay, last, load, drop, ld_sop;
    logic [HDR_W-1:0] ld_data;

    assign free     = !m_valid | m_ready;
    assign start_ok = (state == ST_IDLE) & cfg_start & (cfg_len != '0);
    assign load_pay = smp_valid & (state == ST_RUN) & free;
    assign last     = wcnt == len - 1'b1;
    assign busy     = state != ST_IDLE;

`ifdef RX_TIMESTAMP_EN
    localparam state_t ST_BEGIN = ST_HDR;
    logic [HDR_W-1:0] ts_cnt;
    logic             load_hdr;

    assign load_hdr = (state == ST_HDR) & free;
    assign load     = load_pay | load_hdr;
    // Every sample seen in HDR is lost: either it collides with the header load or the register is blocked.
    assign drop     = smp_valid & ((state == ST_HDR) | ((state == ST_RUN) & !free));
    assign ld_data  = load_hdr ? ts_cnt : smp_data;
    assign ld_sop   = load_hdr;

    always_ff @(posedge Clk) begin
        if (!Rst_n) ts_cnt <= '0;
        else if (smp_valid) ts_cnt <= ts_cnt + 1'b1;
    end
`else
    localparam state_t ST_BEGIN = ST_RUN;

    assign load    = load_pay;
    assign drop    = smp_valid & (state == ST_RUN) & !free;
    assign ld_data = smp_data;
    assign ld_sop  = wcnt == '0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_BEGIN;
`ifdef RX_TIMESTAMP_EN
            ST_HDR:   if (free) state_nx = ST_RUN;
`endif
            ST_RUN:   if (load_pay & last) state_nx = (cont & !stop_pending & !cfg_stop) ? ST_BEGIN : ST_DRAIN;
            ST_DRAIN: if (m_valid & m_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state        <= ST_IDLE;
            len          <= '0;
            cont         <= 1'b0;
            stop_pending <= 1'b0;
            wcnt         <= '0;
            drop_cnt     <= '0;
            burst_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                len          <= cfg_len;
                cont         <= cfg_continuous;
                stop_pending <= cfg_stop;
                wcnt         <= '0;
                drop_cnt     <= '0;
                burst_cnt    <= '0;
            end else begin
                if (cfg_stop & busy & (state != ST_DRAIN)) stop_pending <= 1'b1;
                if (load_pay) wcnt <= last ? '0 : wcnt + 1'b1;
                if (load_pay & last) burst_cnt <= burst_cnt + 1'b1;
                if (drop & ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    rx_out_reg u_out (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .load    (load),
        .ld_data (ld_data),
        .ld_sop  (ld_sop),
        .ld_eop  (load_pay & last),
        .ready   (m_ready),
        .q_data  (m_data),
        .q_valid (m_valid),
        .q_sop   (m_sop),
        .q_eop   (m_eop)
    );
endmodule

// File: tb/tb_rx_burst_ctrl.sv
// tb_rx_burst_ctrl: directed-vector bench for rx_burst_ctrl; accepted words are captured as {eop,sop,data}.
module tb_rx_burst_ctrl;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [63:0] smp_data = '0;
    logic        smp_valid = 1'b0;
    logic [63:0] m_data;
    logic        m_valid, m_sop, m_eop, busy;
    logic        m_ready = 1'b1;
    logic [15:0] drop_cnt, burst_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [65:0] got[$];

    rx_burst_ctrl dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_len        (cfg_len),
        .cfg_continuous (cfg_continuous),
        .smp_data       (smp_data),
        .smp_valid      (smp_valid),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sop          (m_sop),
        .m_eop          (m_eop),
        .busy           (busy),
        .drop_cnt       (drop_cnt),
        .burst_cnt      (burst_cnt)
    );

    always #5 Clk = ~Clk;

    // Inputs change at posedge+2, so a word valid and ready at negedge is taken at the next posedge.
    always @(negedge Clk)
        if (Rst_n && m_valid && m_ready) got.push_back({m_eop, m_sop, m_data});

    task automatic check(input string tag, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic send(input logic [63:0] d);
        smp_data  = d;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        tick(3);
    endtask

    task automatic start(input logic [15:0] len, input logic cont, input logic stop);
        got.delete();
        cfg_len        = len;
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        cfg_stop       = stop;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
    endtask

    task automatic expect_word(input int i, input logic [63:0] d, input logic s, input logic e);
        check($sformatf("word%0d", i), i < got.size() ? got[i] : 66'bx, {e, s, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_burst", burst_cnt, 0);
        Rst_n = 1'b1;
        tick();
`ifdef RX_TIMESTAMP_EN
        smp_valid = 1'b1;
        tick(100);
        smp_valid = 1'b0;
        start(2, 0, 0);
        check("ts_busy", busy, 1);
        tick();
        check("ts_hdr_valid", m_valid, 1);
        send(64'hD0);
        send(64'hD1);
        tick(2);
        check("ts_count", got.size(), 3);
        expect_word(0, 64'd100, 1, 0);
        expect_word(1, 64'hD0, 0, 0);
        expect_word(2, 64'hD1, 0, 1);
        check("ts_burst", burst_cnt, 1);
        check("ts_idle", busy, 0);
`else
        // single shot, len=4
        start(4, 0, 0);
        check("s1_busy", busy, 1);
        smp_data  = 64'hA0;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        check("s1_lat_valid", m_valid, 1);
        check("s1_lat_data", m_data, 64'hA0);
        tick(3);
        for (int i = 1; i < 8; i++) send(64'hA0 + i);
        check("s1_count", got.size(), 4);
        for (int i = 0; i < 4; i++) expect_word(i, 64'hA0 + i, i == 0, i == 3);
        check("s1_burst", burst_cnt, 1);
        check("s1_idle", busy, 0);

        // backpressure: B2, B3 arrive while B1 is held
        start(4, 0, 0);
        send(64'hB0);
        smp_data  = 64'hB1;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        m_ready   = 1'b0;
        tick(3);
        send(64'hB2);
        send(64'hB3);
        check("s2_hold_data", m_data, 64'hB1);
        check("s2_drop", drop_cnt, 2);
        m_ready = 1'b1;
        send(64'hB4);
        send(64'hB5);
        tick(2);
        check("s2_count", got.size(), 4);
        expect_word(0, 64'hB0, 1, 0);
        expect_word(1, 64'hB1, 0, 0);
        expect_word(2, 64'hB4, 0, 0);
        expect_word(3, 64'hB5, 0, 1);
        check("s2_idle", busy, 0);

        // continuous len=3, stop during third burst
        start(3, 1, 0);
        check("s3_drop_clr", drop_cnt, 0);
        for (int i = 0; i < 11; i++) begin
            if (i == 7) cfg_stop = 1'b1;
            send(64'hC0 + i);
        end
        check("s3_count", got.size(), 9);
        for (int i = 0; i < 9; i++) expect_word(i, 64'hC0 + i, i % 3 == 0, i % 3 == 2);
        check("s3_burst", burst_cnt, 3);
        check("s3_idle", busy, 0);

        // len=0 start is ignored
        start(0, 0, 0);
        check("s4_len0_busy", busy, 0);
        send(64'hEE);
        check("s4_len0_words", got.size(), 0);

        // len=1 continuous, stop coincident with third eop
        start(1, 1, 0);
        send(64'hD0);
        send(64'hD1);
        cfg_stop = 1'b1;
        send(64'hD2);
        send(64'hD3);
        check("s4_len1_count", got.size(), 3);
        for (int i = 0; i < 3; i++) expect_word(i, 64'hD0 + i, 1, 1);
        check("s4_len1_burst", burst_cnt, 3);
        check("s4_len1_idle", busy, 0);

        // start and stop together give exactly one burst
        start(2, 1, 1);
        for (int i = 0; i < 4; i++) send(64'hE0 + i);
        check("s4_ss_count", got.size(), 2);
        expect_word(1, 64'hE1, 0, 1);
        check("s4_ss_burst", burst_cnt, 1);

        // reset mid-burst with a held word
        start(4, 0, 0);
        m_ready = 1'b0;
        send(64'hF0);
        check("s5_pre_valid", m_valid, 1);
        Rst_n = 1'b0;
        tick();
        check("s5_valid", m_valid, 0);
        check("s5_flags", {m_sop, m_eop}, 0);
        check("s5_data", m_data, 0);
        check("s5_busy", busy, 0);
        Rst_n   = 1'b1;
        m_ready = 1'b1;
        start(2, 0, 0);
        send(64'h10);
        send(64'h11);
        tick(2);
        check("s5_count", got.size(), 2);
        expect_word(0, 64'h10, 1, 0);
        expect_word(1, 64'h11, 0, 1);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
